lcd_bus_driver: RTL and testbench



---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_bus_driver_timer.sv | 27 ++
 rtl/lcd_bus_driver.sv | 173 +++++++++++++++++
 tb/tb_lcd_bus_driver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 LCD bus driver: FSM states, controller
// command bytes and the LSU LCD register field positions.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

    localparam int unsigned LSU_ON_BIT   = 31;
    localparam int unsigned LSU_RS_BIT   = 9;
    localparam int unsigned LSU_DATA_MSB = 7;
    localparam int unsigned LSU_DATA_LSB = 0;

    // Clear and Return Home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME ||
                       data == (CMD_HOME | CMD_CLEAR));
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_8B2L;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_CLEAR;
            default: return CMD_ENTRY_INC;
        endcase
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_driver_timer.sv
// Loadable down-counter; o_done flags the last cycle of the loaded interval.
module lcd_timer #(
    parameter int unsigned CW      = 20,
    parameter int unsigned RST_VAL = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic          o_done
);

    logic [CW-1:0] count_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= CW'(RST_VAL);
        end else if (i_load) begin
            count_q <= i_load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign o_done = (count_q == CW'(1));

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver with setup/enable/hold/execute timing.
// Optional LCD_INIT_SEQ_EN: issue 0x38,0x0C,0x01,0x06 automatically after power-up.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP_CYC = 4,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_CLEAR_CYC = 82000,
    parameter int unsigned T_PWRUP_CYC = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_lcd_on,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    output logic       o_busy,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int unsigned T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC),
                                              max2(T_HOLD_CYC, T_EXEC_CYC)),
                                         max2(T_CLEAR_CYC, T_PWRUP_CYC));
    localparam int unsigned CW = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC);
    localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR_CYC);

    lcd_state_t    state_q, state_n;
    logic          rs_q, rs_n;
    logic [7:0]    data_q, data_n;
    logic          en_q;
    logic          lcd_on_q;
    logic          ready;
    logic          t_load;
    logic [CW-1:0] t_load_val;
    logic          t_done;
`ifdef LCD_INIT_SEQ_EN
    logic [1:0]    idx_q, idx_n;
    logic          init_q, init_n;
`endif

    lcd_timer #(
        .CW      (CW),
        .RST_VAL (T_PWRUP_CYC)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (t_load),
        .i_load_val (t_load_val),
        .o_done     (t_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_PWRUP;
            rs_q     <= 1'b0;
            data_q   <= '0;
            en_q     <= 1'b0;
            lcd_on_q <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            idx_q    <= '0;
            init_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            rs_q     <= rs_n;
            data_q   <= data_n;
            en_q     <= (state_n == ST_PULSE);
            lcd_on_q <= i_lcd_on;
`ifdef LCD_INIT_SEQ_EN
            idx_q    <= idx_n;
            init_q   <= init_n;
`endif
        end
    end

    // Ready is asserted during the last cycle of EXEC/PWRUP too, so a held
    // valid is accepted on the very edge the previous wait expires.
    always_comb begin
        state_n    = state_q;
        rs_n       = rs_q;
        data_n     = data_q;
        t_load     = 1'b0;
        t_load_val = '0;
        ready      = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        idx_n      = idx_q;
        init_n     = init_q;
`endif
        case (state_q)
            ST_PWRUP: if (t_done) begin
`ifdef LCD_INIT_SEQ_EN
                state_n    = ST_SETUP;
                rs_n       = 1'b0;
                data_n     = init_byte(2'd0);
                idx_n      = 2'd0;
                init_n     = 1'b1;
                t_load     = 1'b1;
                t_load_val = LD_SETUP;
`else
                ready      = 1'b1;
`endif
            end
            ST_IDLE: ready = 1'b1;
            ST_SETUP: if (t_done) begin
                state_n    = ST_PULSE;
                t_load     = 1'b1;
                t_load_val = LD_EN;
            end
            ST_PULSE: if (t_done) begin
                state_n    = ST_HOLD;
                t_load     = 1'b1;
                t_load_val = LD_HOLD;
            end
            ST_HOLD: if (t_done) begin
                state_n    = ST_EXEC;
                t_load     = 1'b1;
                t_load_val = is_long_cmd(rs_q, data_q) ? LD_CLEAR : LD_EXEC;
            end
            ST_EXEC: if (t_done) begin
`ifdef LCD_INIT_SEQ_EN
                if (init_q && idx_q != 2'd3) begin
                    state_n    = ST_SETUP;
                    rs_n       = 1'b0;
                    data_n     = init_byte(idx_q + 2'd1);
                    idx_n      = idx_q + 2'd1;
                    t_load     = 1'b1;
                    t_load_val = LD_SETUP;
                end else begin
                    init_n = 1'b0;
                    ready  = 1'b1;
                end
`else
                ready = 1'b1;
`endif
            end
            default: state_n = ST_PWRUP;
        endcase

        if (ready) begin
            t_load = 1'b1;
            if (i_cmd_valid) begin
                state_n    = ST_SETUP;
                rs_n       = i_cmd_rs;
                data_n     = i_cmd_data;
                t_load_val = LD_SETUP;
            end else begin
                state_n    = ST_IDLE;
                t_load_val = '0;
            end
        end
    end

    assign o_cmd_ready = ready;
    assign o_busy      = ~ready;
    assign o_lcd_on    = lcd_on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed + randomized bench for lcd_bus_driver with a transaction-level timing model.
module tb_lcd_bus_driver;
    import lcd_pkg::*;

    localparam int S = 2, E = 5, H = 2, X = 10, C = 40, P = 20;
    localparam int TMO = 3000;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_lcd_on = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       i_cmd_rs = 1'b0;
    logic [7:0] i_cmd_data = '0;
    logic       o_cmd_ready, o_busy, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    int tests = 0, fails = 0;
    int cyc = 0;

    lcd_bus_driver #(
        .T_SETUP_CYC (S),
        .T_EN_CYC    (E),
        .T_HOLD_CYC  (H),
        .T_EXEC_CYC  (X),
        .T_CLEAR_CYC (C),
        .T_PWRUP_CYC (P)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_lcd_on    (i_lcd_on),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd_rs    (i_cmd_rs),
        .i_cmd_data  (i_cmd_data),
        .o_cmd_ready (o_cmd_ready),
        .o_busy      (o_busy),
        .o_lcd_on    (o_lcd_on),
        .o_lcd_en    (o_lcd_en),
        .o_lcd_rs    (o_lcd_rs),
        .o_lcd_rw    (o_lcd_rw),
        .o_lcd_data  (o_lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // EN pulse observer: edge numbers of rise/fall plus the bus value captured at rise.
    logic       prev_en = 1'b0;
    int         rise_count = 0, last_rise = -1, last_fall = -1, stab_err = 0, rw_err = 0;
    logic [7:0] last_data = '0;
    logic       last_rs = 1'b0;
    logic [7:0] rise_data [0:255];
    logic       rise_rs [0:255];

    always @(negedge clk) begin
        if (o_lcd_en === 1'b1 && prev_en !== 1'b1) begin
            last_rise = cyc;
            last_data = o_lcd_data;
            last_rs   = o_lcd_rs;
            if (rise_count < 256) begin
                rise_data[rise_count] = o_lcd_data;
                rise_rs[rise_count]   = o_lcd_rs;
            end
            rise_count = rise_count + 1;
        end
        if (o_lcd_en !== 1'b1 && prev_en === 1'b1) last_fall = cyc;
        if (o_lcd_en === 1'b1 && prev_en === 1'b1 &&
            (o_lcd_data !== last_data || o_lcd_rs !== last_rs)) stab_err = stab_err + 1;
        if (o_lcd_rw !== 1'b0 || o_busy !== ~o_cmd_ready) rw_err = rw_err + 1;
        prev_en = o_lcd_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int offs(input logic rs, input logic [7:0] d);
        int w;
        w = (rs == 1'b0 && d >= 8'd1 && d <= 8'd3) ? C : X;
        return S + E + H + w;
    endfunction

    function automatic int pwrup_total();
        int t;
        t = P;
`ifdef LCD_INIT_SEQ_EN
        t = t + offs(1'b0, 8'h38) + offs(1'b0, 8'h0C) + offs(1'b0, 8'h01) + offs(1'b0, 8'h06);
`endif
        return t;
    endfunction

    // Caller sits at a negedge; acc is the first edge at which an accept can occur.
    task automatic wait_ready(output int acc);
        int n;
        n = 0;
        while (o_cmd_ready !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (n >= TMO) chk("ready_timeout", {31'd0, o_cmd_ready}, 32'd1);
    endtask

    task automatic do_send(input logic rs, input logic [7:0] d, output int k);
        int e;
        logic [31:0] w;
        wait_ready(e);
        w = '0;
        w[LSU_RS_BIT] = rs;
        w[LSU_DATA_MSB:LSU_DATA_LSB] = d;
        i_cmd_valid = 1'b1;
        i_cmd_rs    = w[LSU_RS_BIT];
        i_cmd_data  = w[LSU_DATA_MSB:LSU_DATA_LSB];
        @(posedge clk);
        @(negedge clk);
        k = cyc;
        i_cmd_valid = 1'b0;
        i_cmd_rs    = 1'($urandom);
        i_cmd_data  = 8'($urandom);
    endtask

    task automatic xfer(input string tag, input logic rs, input logic [7:0] d);
        int k, r, n0;
        n0 = rise_count;
        do_send(rs, d, k);
        wait_ready(r);
        chk({tag, "_ready"}, r - k, offs(rs, d));
        chk({tag, "_rise"}, last_rise, k + S);
        chk({tag, "_fall"}, last_fall, k + S + E);
        chk({tag, "_data"}, {24'd0, last_data}, {24'd0, d});
        chk({tag, "_rs"}, {31'd0, last_rs}, {31'd0, rs});
        chk({tag, "_pulses"}, rise_count - n0, 1);
        chk({tag, "_held"}, {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, rs, d});
    endtask

    task automatic release_and_check_pwrup(input string tag);
        int rel, acc, n0;
        logic [31:0] lsu;
        logic [7:0] exp_init [0:3];
        exp_init[0] = 8'h38; exp_init[1] = 8'h0C; exp_init[2] = 8'h01; exp_init[3] = 8'h06;
        n0 = rise_count;
        i_rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < 6; i++) begin
            lsu = $urandom;
            i_lcd_on = lsu[LSU_ON_BIT];
            @(negedge clk);
            chk({tag, "_lcd_on"}, {31'd0, o_lcd_on}, {31'd0, lsu[LSU_ON_BIT]});
        end
        wait_ready(acc);
        chk({tag, "_pwrup_len"}, acc - rel, pwrup_total());
`ifdef LCD_INIT_SEQ_EN
        chk({tag, "_init_pulses"}, rise_count - n0, 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_init_data"}, {24'd0, rise_data[n0 + i]}, {24'd0, exp_init[i]});
            chk({tag, "_init_rs"}, {31'd0, rise_rs[n0 + i]}, 32'd0);
        end
`else
        chk({tag, "_no_en"}, rise_count - n0, 0);
`endif
    endtask

    initial begin
        int k1, k2, r, n0, n;
        logic       rs;
        logic [7:0] d;

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, o_cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd1);
        chk("rst_en", {31'd0, o_lcd_en}, 32'd0);
        chk("rst_rs", {31'd0, o_lcd_rs}, 32'd0);
        chk("rst_rw", {31'd0, o_lcd_rw}, 32'd0);
        chk("rst_data", {24'd0, o_lcd_data}, 32'd0);
        chk("rst_lcd_on", {31'd0, o_lcd_on}, 32'd0);
        @(negedge clk);
        release_and_check_pwrup("pwr1");

        // Directed bytes, including both execution-wait classes
        xfer("data41", 1'b1, 8'h41);
        xfer("clear", 1'b0, 8'h01);
        xfer("ddram80", 1'b0, 8'h80);
        xfer("home02", 1'b0, 8'h02);
        xfer("home03", 1'b0, 8'h03);
        xfer("cmd04", 1'b0, 8'h04);
        xfer("data01", 1'b1, 8'h01);
        xfer("cmd00", 1'b0, 8'h00);

        // Randomized bytes, biased toward the short-command boundary
        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom);
            d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            xfer("rand", rs, d);
        end

        // Back-to-back with valid held: second accept on the ready-return edge
        n0 = rise_count;
        do_send(1'b1, 8'h11, k1);
        i_cmd_valid = 1'b1;
        i_cmd_rs    = 1'b1;
        i_cmd_data  = 8'h22;
        n = 0;
        while (o_cmd_ready !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_data", {24'd0, last_data}, 32'h11);
        @(posedge clk);
        @(negedge clk);
        k2 = cyc;
        i_cmd_valid = 1'b0;
        chk("b2b_gap", k2 - k1, offs(1'b1, 8'h11));
        // One-cycle valid pulse while busy must be dropped
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_data  = 8'h55;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        wait_ready(r);
        chk("b2b_second_ready", r - k2, offs(1'b1, 8'h22));
        chk("b2b_pulses", rise_count - n0, 2);
        chk("b2b_second_data", {24'd0, last_data}, 32'h22);
        chk("b2b_held", {24'd0, o_lcd_data}, 32'h22);
        repeat (3) @(negedge clk);
        chk("idle_no_pulse", rise_count - n0, 2);

        // Reset while EN is high
        do_send(1'b1, 8'h5A, k1);
        n = 0;
        while (o_lcd_en !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_en_seen", {31'd0, o_lcd_en}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("mid_rst_en", {31'd0, o_lcd_en}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_cmd_ready}, 32'd0);
        chk("mid_rst_data", {24'd0, o_lcd_data}, 32'd0);
        @(negedge clk);
        release_and_check_pwrup("pwr2");
        xfer("post_rst", 1'b1, 8'h7E);

        chk("en_stability", stab_err, 0);
        chk("rw_busy_invariant", rw_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
